// File: rtl/rv32_m_lsu_pkg.sv
// ---------------------------------------------------------------------------
// rv32_m_lsu_pkg
// Shared definitions for the RV32 memory-stage load/store unit:
//   - funct3 width/sign codes (B, H, W, BU, HU)
//   - FSM state enumeration
//   - LSU_ byte-enable base patterns
//   - helpers for misalignment detection and store lane formatting
// The helpers take only funct3[1:0] (the access size); funct3[2] carries
// signedness, which matters for loads only.
// ---------------------------------------------------------------------------
package rv32_m_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LSU_BE_B = 4'b0001;
    localparam logic [3:0] LSU_BE_H = 4'b0011;
    localparam logic [3:0] LSU_BE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Halfwords must sit on even addresses, words on multiples of four.
    // Size codes 2'b10 and 2'b11 are both handled as word accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic result;
        case (size)
            2'b00:   result = 1'b0;
            2'b01:   result = off[0];
            default: result = (off != 2'b00);
        endcase
        return result;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] result;
        case (size)
            2'b00:   result = LSU_BE_B << off;
            2'b01:   result = LSU_BE_H << off;
            default: result = LSU_BE_W;
        endcase
        return result;
    endfunction

    // Narrow store data is replicated across every lane so that the byte
    // enables alone select the written lane.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] result;
        case (size)
            2'b00:   result = {4{data[7:0]}};
            2'b01:   result = {2{data[15:0]}};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rv32_m_load_align.sv
// ---------------------------------------------------------------------------
// rv32_m_load_align
// Combinational load lane extraction and sign/zero extension.
// Ports:
//   funct3  in  3   load width/sign code of the outstanding load
//   offset  in  2   byte offset of the load within the word
//   rdata   in  32  raw word returned by the data bus
//   data    out 32  extracted, extended load result
// ---------------------------------------------------------------------------
module rv32_m_load_align
    import rv32_m_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        // Halfword loads are always even-aligned, so offset[1] alone picks the lane.
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data = {24'h0, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data = {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32_m_lsu.sv
// ---------------------------------------------------------------------------
// rv32_m_lsu
// Memory-stage load/store unit for an RV32 pipeline. Accepts one load or
// store at a time, checks alignment, drives a simple req/gnt + rvalid data
// bus, and returns extended load data with a one-cycle done pulse.
// Bus waits are bounded by TIMEOUT_CYCLES (must be >= 2) in both the
// request and response phases.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   valid_i, mem_read_i,
//   mem_write_i, funct3_i,
//   addr_i, store_data_i           memory-stage instruction
//   stall_o                        freeze upstream pipeline
//   done_o, load_data_o            completion pulse and load result
//   misaligned_o, bus_err_o        one-cycle exception pulses
//   dmem_req_o, dmem_we_o,
//   dmem_be_o, dmem_addr_o,
//   dmem_wdata_o                   data bus request
//   dmem_gnt_i, dmem_rvalid_i,
//   dmem_rdata_i                   data bus grant and read response
// ---------------------------------------------------------------------------
module rv32_m_lsu
    import rv32_m_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    // Counter runs 0 .. TIMEOUT_CYCLES-1; the abort fires on the edge that
    // ends the TIMEOUT_CYCLES-th waiting cycle of a phase.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       off_reg;

    logic             start;
    logic             accept;
    logic             misaligned;
    logic             cnt_expired;
    logic [31:0]      aligned_data;

    assign start       = valid_i & (mem_read_i | mem_write_i);
    assign accept      = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));
    assign misaligned  = is_misaligned(funct3_i[1:0], addr_i[1:0]);
    assign cnt_expired = (cnt_reg == CNT_LAST);

    // The accept term is combinational so the pipeline freezes in the very
    // cycle an aligned access is taken. Gating with reset_i keeps the output
    // low while reset is held even if the pipeline presents a request.
    assign stall_o = ~reset_i &
                     ((state_reg == ST_REQ) | (state_reg == ST_RESP) | (accept & ~misaligned));

    rv32_m_load_align u_load_align (
        .funct3 (funct3_reg),
        .offset (off_reg),
        .rdata  (dmem_rdata_i),
        .data   (aligned_data)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            funct3_reg   <= '0;
            off_reg      <= '0;
            done_o       <= 1'b0;
            load_data_o  <= 32'h0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'h0;
            dmem_addr_o  <= 32'h0;
            dmem_wdata_o <= 32'h0;
        end else begin
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    state_reg <= ST_IDLE;
                    if (accept) begin
                        if (misaligned) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            state_reg    <= ST_REQ;
                            cnt_reg      <= '0;
                            funct3_reg   <= funct3_i;
                            off_reg      <= addr_i[1:0];
                            dmem_req_o   <= 1'b1;
                            // Read and write together is treated as a load.
                            dmem_we_o    <= mem_write_i & ~mem_read_i;
                            dmem_be_o    <= store_be(funct3_i[1:0], addr_i[1:0]);
                            dmem_addr_o  <= {addr_i[31:2], 2'b00};
                            dmem_wdata_o <= store_wdata(funct3_i[1:0], store_data_i);
                        end
                    end
                end

                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        cnt_reg    <= '0;
                        if (dmem_we_o) begin
                            state_reg <= ST_DONE;
                            done_o    <= 1'b1;
                        end else begin
                            state_reg <= ST_RESP;
                        end
                    end else if (cnt_expired) begin
                        dmem_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RESP: begin
                    // A grant seen here is meaningless; only rvalid matters.
                    if (dmem_rvalid_i) begin
                        load_data_o <= aligned_data;
                        done_o      <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else if (cnt_expired) begin
                        bus_err_o <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
